// File: rtl/i2c_reg_poller.sv
// Periodic I2C register sweeper: for each entry, writes the register pointer, then reads one byte
// back into a small register file that a synchronous read port exposes.
module i2c_reg_poller #(
  parameter logic [6:0] DEVICE_ADDR = 7'h6B,
  parameter logic [7:0] FIRST_REG   = 8'h08,
  parameter int         NUM_REGS    = 4,
  parameter int         POLL_PERIOD = 4800000,
  parameter int         TIMEOUT     = 480000,
  localparam int        IW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          enable,
  output logic [7:0]    address,
  output logic          transfer_start,
  output logic          transfer_continues,
  output logic [7:0]    data_tx,
  input  logic          transfer_ready,
  input  logic          interrupt,
  input  logic          transaction_complete,
  input  logic          nack,
  input  logic [7:0]    data_rx,
  input  logic [IW-1:0] rd_index,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          sweep_done,
  output logic [7:0]    err_count
);

  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_READY, S_START_RD, S_WAIT_WR, S_WAIT_RD, S_NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   per_q, per_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      err_q, err_d;
  logic            mode_q;
  logic [7:0]      tx_q;
  logic [7:0]      data_q [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;

  logic            start, start_rd, wr_en, wr_ok, err_inc, done_ev, tmo_hit;
  logic [7:0]      ptr;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign done_ev = interrupt && transaction_complete;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
  assign ptr     = FIRST_REG + {{(8-IW){1'b0}}, idx_q};

  // Start-cycle values appear combinationally and are then held until the next start.
  assign transfer_start     = start;
  assign transfer_continues = 1'b0;
  assign address            = {DEVICE_ADDR, start ? start_rd : mode_q};
  assign data_tx            = start ? ptr : tx_q;
  assign busy               = (state_q != S_IDLE);
  assign err_count          = err_q;
  assign rd_data            = rd_data_q;
  assign rd_valid           = rd_valid_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    per_d      = per_q;
    tmo_d      = tmo_q;
    start      = 1'b0;
    start_rd   = 1'b0;
    wr_en      = 1'b0;
    wr_ok      = 1'b0;
    err_inc    = 1'b0;
    sweep_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (per_q != PW'(POLL_PERIOD)) per_d = per_q + 1'b1;
        // >= rather than == so a sweep can still start if enable rises after saturation
        if (enable && per_q >= PW'(POLL_PERIOD - 1)) begin
          idx_d   = '0;
          state_d = S_WAIT_READY;
        end
      end
      S_WAIT_READY: begin
        if (transfer_ready) begin
          start   = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT_WR;
        end
      end
      S_START_RD: begin
        start    = 1'b1;
        start_rd = 1'b1;
        tmo_d    = '0;
        state_d  = S_WAIT_RD;
      end
      S_WAIT_WR: begin
        if (done_ev) begin
          if (nack) begin
            wr_en   = 1'b1;
            err_inc = 1'b1;
            state_d = S_NEXT;
          end else begin
            state_d = S_START_RD;
          end
        end else if (tmo_hit) begin
          wr_en   = 1'b1;
          err_inc = 1'b1;
          state_d = S_NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (done_ev) begin
          wr_en   = 1'b1;
          wr_ok   = !nack;
          err_inc = nack;
          state_d = S_NEXT;
        end else if (tmo_hit) begin
          wr_en   = 1'b1;
          err_inc = 1'b1;
          state_d = S_NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (idx_q == IW'(NUM_REGS - 1)) begin
          sweep_done = 1'b1;
          per_d      = '0;
          state_d    = S_IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_WAIT_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_inc ? sat_inc8(err_q) : err_q;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      per_q   <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
      mode_q  <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      if (start) begin
        mode_q <= start_rd;
        tx_q   <= ptr;
      end
    end
  end

  // Read port is write-first: an entry updated this cycle is returned with its new contents.
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    if (int'(rd_index) < NUM_REGS) begin
      if (wr_en && rd_index == idx_q) begin
        rd_valid_d = wr_ok;
        rd_data_d  = wr_ok ? data_rx : data_q[rd_index];
      end else begin
        rd_valid_d = valid_q[rd_index];
        rd_data_d  = data_q[rd_index];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) data_q[i] <= '0;
      valid_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        valid_q[idx_q] <= wr_ok;
        if (wr_ok) data_q[idx_q] <= data_rx;
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_i2c_reg_poller.sv
// Bench for i2c_reg_poller: an i2c_master/slave stand-in answers each transaction, a monitor logs
// every transfer_start, and each test compares the log against its queue of expected transactions.
module tb_i2c_reg_poller;
  localparam int NR  = 2;
  localparam int PP  = 100;
  localparam int TO  = 50;
  localparam int LAT = 6;

  logic       clk_in = 1'b0, reset = 1'b1, enable = 1'b0, transfer_ready = 1'b0;
  logic       interrupt = 1'b0, transaction_complete = 1'b0, nack = 1'b0;
  logic [7:0] data_rx = 8'h00;
  logic [0:0] rd_index = 1'b0;
  logic [7:0] address, data_tx, rd_data, err_count;
  logic       transfer_start, transfer_continues, rd_valid, busy, sweep_done;

  int checks = 0, failures = 0;
  int cyc = 0, rel_cyc = 0, done_cnt = 0;
  int slave_mode = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int obs_cyc[$];
  int err_cyc[$];
  bit pend = 1'b0, pend_rd = 1'b0;
  int cnt = 0;
  logic [7:0] ptr = 8'h00, last_err = 8'h00;

  i2c_reg_poller #(.DEVICE_ADDR(7'h6B), .FIRST_REG(8'h08), .NUM_REGS(NR),
                   .POLL_PERIOD(PP), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .address(address),
    .transfer_start(transfer_start), .transfer_continues(transfer_continues),
    .data_tx(data_tx), .transfer_ready(transfer_ready), .interrupt(interrupt),
    .transaction_complete(transaction_complete), .nack(nack), .data_rx(data_rx),
    .rd_index(rd_index), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .sweep_done(sweep_done), .err_count(err_count));

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [7:0] reg_val(input logic [7:0] r);
    case (r)
      8'h08:   return 8'hA5;
      8'h09:   return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  // Slave stand-in and monitor. slave_mode: 0 responsive, 1 NACK the write to reg 0x08, 2 silent.
  always @(negedge clk_in) begin
    #2;
    if (reset) begin
      pend = 1'b0; interrupt = 1'b0; transaction_complete = 1'b0; nack = 1'b0;
      last_err = err_count;
    end else begin
      interrupt = 1'b0; transaction_complete = 1'b0; nack = 1'b0;
      if (sweep_done) done_cnt++;
      if (err_count != last_err) begin err_cyc.push_back(cyc); last_err = err_count; end
      if (pend) begin
        if (cnt == 0) begin
          pend = 1'b0; interrupt = 1'b1; transaction_complete = 1'b1;
          if (!pend_rd) nack = (slave_mode == 1 && ptr == 8'h08);
          else data_rx = reg_val(ptr);
        end else cnt--;
      end
      if (transfer_start) begin
        obs_q.push_back({address, data_tx});
        obs_cyc.push_back(cyc);
        if (slave_mode != 2) begin
          pend = 1'b1; cnt = LAT; pend_rd = address[0];
          if (!address[0]) ptr = data_tx;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    exp_q.delete(); obs_q.delete(); obs_cyc.delete(); err_cyc.delete(); done_cnt = 0;
    @(negedge clk_in);
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int k = 0;
    while (done_cnt < 1 && k < maxc) begin @(negedge clk_in); #3; k++; end
    checks++;
    if (done_cnt < 1) begin
      failures++; $display("FAIL %s_sweep_wait: sweep_done count=%0d required=1 within %0d cycles", name, done_cnt, maxc);
    end
  endtask

  task automatic read_entry(input int i, output logic [7:0] d, output logic v);
    @(negedge clk_in); rd_index = 1'(i);
    @(negedge clk_in); #3; d = rd_data; v = rd_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    checks += 8;
    if (transfer_start !== 1'b0) begin failures++; $display("FAIL rst_start: got %b required 0", transfer_start); end
    if (data_tx !== 8'h00) begin failures++; $display("FAIL rst_data_tx: got %h required 00", data_tx); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (sweep_done !== 1'b0) begin failures++; $display("FAIL rst_sweep_done: got %b required 0", sweep_done); end
    if (err_count !== 8'h00) begin failures++; $display("FAIL rst_err: got %h required 00", err_count); end
    if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data: got %h required 00", rd_data); end
    if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid: got %b required 0", rd_valid); end
    if (address !== 8'hD6) begin failures++; $display("FAIL rst_address: got %h required d6", address); end
  endtask

  task automatic test_responsive();
    logic [7:0] d; logic v;
    slave_mode = 0; enable = 1'b1; transfer_ready = 1'b1;
    do_reset();
    exp_q = '{16'hD608, 16'hD708, 16'hD609, 16'hD709};
    wait_done("resp", PP + 200);
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] - rel_cyc != PP) begin
      failures++; $display("FAIL resp_first_start_delay: got %0d required %0d", (obs_cyc.size() != 0) ? obs_cyc[0] - rel_cyc : -1, PP);
    end
    while (exp_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL resp_txn: got none required %h", exp_q.pop_front()); end
      else if (obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL resp_txn: got %h required %h", obs_q.pop_front(), exp_q.pop_front()); end
      else begin void'(obs_q.pop_front()); void'(exp_q.pop_front()); end
    end
    read_entry(1, d, v);
    checks += 5;
    if (d !== 8'h3C || v !== 1'b1) begin failures++; $display("FAIL resp_entry1: got %h/%b required 3c/1", d, v); end
    read_entry(0, d, v);
    if (d !== 8'hA5 || v !== 1'b1) begin failures++; $display("FAIL resp_entry0: got %h/%b required a5/1", d, v); end
    if (obs_q.size() != 0) begin failures++; $display("FAIL resp_extra_txn: got %0d extra required 0", obs_q.size()); end
    if (done_cnt != 1) begin failures++; $display("FAIL resp_sweep_done_count: got %0d required 1", done_cnt); end
    if (err_count !== 8'h00) begin failures++; $display("FAIL resp_err: got %h required 00", err_count); end
  endtask

  task automatic test_nack_write();
    logic [7:0] d; logic v;
    slave_mode = 1; enable = 1'b1; transfer_ready = 1'b1;
    do_reset();
    exp_q = '{16'hD608, 16'hD609, 16'hD709};
    wait_done("nack", PP + 200);
    while (exp_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL nack_txn: got none required %h", exp_q.pop_front()); end
      else if (obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL nack_txn: got %h required %h", obs_q.pop_front(), exp_q.pop_front()); end
      else begin void'(obs_q.pop_front()); void'(exp_q.pop_front()); end
    end
    read_entry(0, d, v);
    checks += 3;
    if (d !== 8'h00 || v !== 1'b0) begin failures++; $display("FAIL nack_entry0: got %h/%b required 00/0", d, v); end
    read_entry(1, d, v);
    if (d !== 8'h3C || v !== 1'b1) begin failures++; $display("FAIL nack_entry1: got %h/%b required 3c/1", d, v); end
    if (err_count !== 8'h01) begin failures++; $display("FAIL nack_err: got %h required 01", err_count); end
  endtask

  task automatic test_timeout();
    logic [7:0] d; logic v;
    slave_mode = 2; enable = 1'b1; transfer_ready = 1'b1;
    do_reset();
    exp_q = '{16'hD608, 16'hD609};
    wait_done("tmo", PP + 300);
    for (int i = 0; i < NR; i++) begin
      checks++;
      // err_count is registered, so it shows the abandon on the cycle after the decision
      if (obs_cyc.size() <= i || err_cyc.size() <= i ||
          err_cyc[i] - obs_cyc[i] < TO || err_cyc[i] - obs_cyc[i] > TO + 1) begin
        failures++; $display("FAIL tmo_abandon_delay%0d: got %0d required %0d..%0d", i,
          (obs_cyc.size() > i && err_cyc.size() > i) ? err_cyc[i] - obs_cyc[i] : -1, TO, TO + 1);
      end
    end
    while (exp_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL tmo_txn: got none required %h", exp_q.pop_front()); end
      else if (obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL tmo_txn: got %h required %h", obs_q.pop_front(), exp_q.pop_front()); end
      else begin void'(obs_q.pop_front()); void'(exp_q.pop_front()); end
    end
    read_entry(0, d, v);
    checks += 3;
    if (v !== 1'b0) begin failures++; $display("FAIL tmo_entry0_valid: got %b required 0", v); end
    if (err_count !== 8'(NR)) begin failures++; $display("FAIL tmo_err: got %h required %h", err_count, 8'(NR)); end
    if (done_cnt != 1) begin failures++; $display("FAIL tmo_sweep_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_ready_low();
    int k = 0; int early = 0;
    slave_mode = 0; enable = 1'b1; transfer_ready = 1'b0;
    do_reset();
    while (!busy && k < PP + 10) begin @(negedge clk_in); #3; k++; end
    checks++;
    if (!busy) begin failures++; $display("FAIL rdy_sweep_begin: busy got 0 required 1"); end
    repeat (200) begin @(negedge clk_in); #3; if (transfer_start) early++; end
    checks += 6;
    if (early != 0 || obs_q.size() != 0) begin failures++; $display("FAIL rdy_held_start: got %0d starts required 0", early + obs_q.size()); end
    if (err_count !== 8'h00) begin failures++; $display("FAIL rdy_no_timeout: err got %h required 00", err_count); end
    @(negedge clk_in); transfer_ready = 1'b1; #3;
    if (transfer_start !== 1'b1) begin failures++; $display("FAIL rdy_start_fires: got %b required 1", transfer_start); end
    if (address !== 8'hD6) begin failures++; $display("FAIL rdy_address: got %h required d6", address); end
    if (data_tx !== 8'h08) begin failures++; $display("FAIL rdy_data_tx: got %h required 08", data_tx); end
    if (busy !== 1'b1) begin failures++; $display("FAIL rdy_busy: got %b required 1", busy); end
  endtask

  task automatic test_enable();
    int k = 0;
    slave_mode = 0; enable = 1'b0; transfer_ready = 1'b1;
    do_reset();
    repeat (3 * PP) @(negedge clk_in);
    #3;
    checks += 2;
    if (obs_q.size() != 0) begin failures++; $display("FAIL en_low_start: got %0d starts required 0", obs_q.size()); end
    if (busy !== 1'b0) begin failures++; $display("FAIL en_low_busy: got %b required 0", busy); end
    @(negedge clk_in); enable = 1'b1;
    while (obs_q.size() == 0 && k < PP + 10) begin @(negedge clk_in); #3; k++; end
    @(negedge clk_in); enable = 1'b0;
    wait_done("en", PP + 200);
    repeat (3 * PP) @(negedge clk_in);
    #3;
    checks += 2;
    if (obs_q.size() != 2 * NR) begin failures++; $display("FAIL en_mid_sweep_starts: got %0d required %0d", obs_q.size(), 2 * NR); end
    if (done_cnt != 1) begin failures++; $display("FAIL en_mid_sweep_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    slave_mode = 0; enable = 1'b1; transfer_ready = 1'b1;
    do_reset();
    while (obs_q.size() < 2 && k < PP + 50) begin @(negedge clk_in); #3; k++; end
    repeat (2) @(negedge clk_in);
    #1;
    checks++;
    if (obs_q.size() < 2 || obs_q[1] !== 16'hD708 || busy !== 1'b1) begin
      failures++; $display("FAIL rmid_in_read: busy got %b starts %0d required 1 and 2", busy, obs_q.size());
    end
    reset = 1'b1; #1;
    checks += 6;
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b required 0", busy); end
    if (transfer_start !== 1'b0) begin failures++; $display("FAIL rmid_start: got %b required 0", transfer_start); end
    if (data_tx !== 8'h00) begin failures++; $display("FAIL rmid_data_tx: got %h required 00", data_tx); end
    if (address !== 8'hD6) begin failures++; $display("FAIL rmid_address: got %h required d6", address); end
    if (err_count !== 8'h00 || sweep_done !== 1'b0) begin failures++; $display("FAIL rmid_err_done: got %h/%b required 00/0", err_count, sweep_done); end
    if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin failures++; $display("FAIL rmid_rd: got %h/%b required 00/0", rd_data, rd_valid); end
    do_reset();
    k = 0;
    while (obs_q.size() == 0 && k < 2 * PP) begin @(negedge clk_in); #3; k++; end
    checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] - rel_cyc < PP) begin
      failures++; $display("FAIL rmid_restart_delay: got %0d required >= %0d", (obs_cyc.size() != 0) ? obs_cyc[0] - rel_cyc : -1, PP);
    end
  endtask

  initial begin
    test_reset();
    test_responsive();
    test_nack_write();
    test_timeout();
    test_ready_low();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
